// File: rtl/seq_stream_ctrl.sv
// rtl/seq_stream_ctrl.sv - word stream to serial bit feeder for the 1011 detector, with match counting
module seq_stream_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              cnt_clr,
  output logic              det_bit,
  output logic              det_reset,
  input  logic              det_seen,
  output logic [CNT_W-1:0]  match_count,
  output logic [CNT_W-1:0]  frame_matches,
  output logic              frame_done
);

  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  sreg;
  logic [BCW-1:0]     bit_cnt;
  logic               last_q;
  logic               load;
  logic [CNT_W-1:0]   frame_cnt, frame_cnt_nxt, match_nxt;

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    det_reset = 1'b0;
    det_bit   = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        s_ready   = 1'b1;
        det_reset = 1'b1;
        if (s_valid) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        det_bit = sreg[DATA_W-1];
        if (bit_cnt == '0) begin
          if (last_q) begin
            state_nxt = DRAIN;
          end else begin
            // A missing word here is a gap: IDLE clears detector history.
            s_ready = 1'b1;
            if (s_valid) load = 1'b1;
            else         state_nxt = IDLE;
          end
        end
      end
      DRAIN: begin
        det_reset = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frame_cnt_nxt = frame_cnt;
    match_nxt     = match_count;
    if (det_seen && frame_cnt != CNT_MAX)   frame_cnt_nxt = frame_cnt + CNT_W'(1);
    if (det_seen && match_count != CNT_MAX) match_nxt = match_count + CNT_W'(1);
    if (cnt_clr)                            match_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      last_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        sreg    <= s_data;
        bit_cnt <= BCW'(DATA_W - 1);
        last_q  <= s_last;
      end else if (state == SHIFT && bit_cnt != '0) begin
        sreg    <= {sreg[DATA_W-2:0], 1'b0};
        bit_cnt <= bit_cnt - BCW'(1);
      end
    end
  end

  // DRAIN captures the frame count including the match seen in that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt     <= '0;
      match_count   <= '0;
      frame_matches <= '0;
      frame_done    <= 1'b0;
    end else begin
      match_count <= match_nxt;
      if (state == DRAIN) begin
        frame_matches <= frame_cnt_nxt;
        frame_cnt     <= '0;
        frame_done    <= 1'b1;
      end else begin
        frame_cnt  <= frame_cnt_nxt;
        frame_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// tb/tb_seq_stream_ctrl.sv - directed and random checks of seq_stream_ctrl against a 1011 detector model
module tb_seq_stream_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_last = 1'b0;
  logic       cnt_clr = 1'b0;

  logic        s_ready, det_bit, det_reset, det_seen, frame_done;
  logic [15:0] match_count, frame_matches;
  logic        s_ready2, det_bit2, det_reset2, det_seen2, frame_done2;
  logic [1:0]  match_count2, frame_matches2;

  int checks = 0;
  int errors = 0;
  int fd_n = 0;
  int last_fm = 0;
  int fm_q[$];

  always #5 clk = ~clk;

  seq_stream_ctrl #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .cnt_clr(cnt_clr), .det_bit(det_bit),
    .det_reset(det_reset), .det_seen(det_seen), .match_count(match_count),
    .frame_matches(frame_matches), .frame_done(frame_done)
  );

  seq_stream_ctrl #(.DATA_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready2),
    .s_data(s_data), .s_last(s_last), .cnt_clr(cnt_clr), .det_bit(det_bit2),
    .det_reset(det_reset2), .det_seen(det_seen2), .match_count(match_count2),
    .frame_matches(frame_matches2), .frame_done(frame_done2)
  );

  // Non-overlapping Moore 1011 detector: 0 none, 1 "1", 2 "10", 3 "101", 4 seen.
  function automatic int det_next(input int st, input logic b);
    case (st)
      0: return b ? 1 : 0;
      1: return b ? 1 : 2;
      2: return b ? 3 : 0;
      3: return b ? 4 : 2;
      default: return b ? 1 : 0;
    endcase
  endfunction

  int dst = 0, dst2 = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)       dst <= 0;
    else if (det_reset) dst <= 0;
    else                dst <= det_next(dst, det_bit);
  end
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)        dst2 <= 0;
    else if (det_reset2) dst2 <= 0;
    else                 dst2 <= det_next(dst2, det_bit2);
  end
  assign det_seen  = (dst == 4);
  assign det_seen2 = (dst2 == 4);

  always @(negedge clk) begin
    if (reset_n && frame_done) begin
      fd_n++;
      last_fm = int'(frame_matches);
      fm_q.push_back(int'(frame_matches));
    end
  end

  task automatic send_word(input logic [7:0] d, input logic l, input int gap);
    int n;
    s_valid = 1'b0;
    if (gap > 0) begin
      n = 0;
      while (!s_ready && n < 100) begin @(negedge clk); n++; end
      repeat (gap) @(negedge clk);
    end
    s_valid = 1'b1; s_data = d; s_last = l;
    n = 0;
    while (!s_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL handshake_timeout s_ready=%0b required 1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_fd(input int target);
    int n = 0;
    #1;
    while (fd_n < target && n < 200) begin @(negedge clk); #1; n++; end
    if (fd_n < target) begin
      checks++; errors++;
      $display("FAIL frame_done_timeout got %0d frames required %0d", fd_n, target);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({s_ready, det_reset, det_bit, frame_done} !== 4'b1100 || match_count !== 16'd0 || frame_matches !== 16'd0) begin
      errors++;
      $display("FAIL reset_state rdy=%0b drst=%0b bit=%0b fd=%0b mc=%0d fm=%0d required 1 1 0 0 0 0",
               s_ready, det_reset, det_bit, frame_done, match_count, frame_matches);
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [7:0] w = 8'hB6;
    s_valid = 1'b1; s_data = w; s_last = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      if (t == 1) s_valid = 1'b0;
      if (t <= 8) begin
        checks++;
        if (det_bit !== w[8-t] || det_reset !== 1'b0) begin
          errors++;
          $display("FAIL single_bit T%0d det_bit=%0b det_reset=%0b required %0b 0", t, det_bit, det_reset, w[8-t]);
        end
      end
      if (t == 6) begin
        checks++;
        if (match_count !== 16'd1) begin errors++; $display("FAIL single_count_T6 got %0d required 1", match_count); end
      end
      if (t == 9) begin
        checks++;
        if (det_reset !== 1'b1 || s_ready !== 1'b0) begin
          errors++; $display("FAIL single_drain det_reset=%0b s_ready=%0b required 1 0", det_reset, s_ready);
        end
      end
      if (t == 10) begin
        checks++;
        if (frame_done !== 1'b1 || frame_matches !== 16'd1 || match_count !== 16'd1) begin
          errors++;
          $display("FAIL single_done fd=%0b fm=%0d mc=%0d required 1 1 1", frame_done, frame_matches, match_count);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w1 = 8'h01;
    logic [7:0] w2 = 8'h60;
    int base = fd_n;
    s_valid = 1'b1; s_data = w1; s_last = 1'b0;
    for (int t = 1; t <= 18; t++) begin
      @(negedge clk);
      if (t == 1) begin s_data = w2; s_last = 1'b1; end
      if (t == 8) begin
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_T8 got %0b required 1", s_ready); end
      end
      if (t >= 1 && t <= 16) begin
        checks++;
        if (det_bit !== (t <= 8 ? w1[8-t] : w2[16-t])) begin
          errors++; $display("FAIL b2b_bit T%0d got %0b required %0b", t, det_bit, (t <= 8 ? w1[8-t] : w2[16-t]));
        end
      end
      if (t == 9) s_valid = 1'b0;
    end
    wait_fd(base + 1);
    checks++;
    if (last_fm != 1) begin errors++; $display("FAIL b2b_frame_matches got %0d required 1", last_fm); end
  endtask

  task automatic test_gap;
    int base = fd_n;
    s_valid = 1'b1; s_data = 8'h01; s_last = 1'b0;
    for (int t = 1; t <= 24; t++) begin
      @(negedge clk);
      if (t == 1) s_valid = 1'b0;
      if (t == 9) begin
        checks++;
        if (det_reset !== 1'b1 || s_ready !== 1'b1) begin
          errors++; $display("FAIL gap_idle det_reset=%0b s_ready=%0b required 1 1", det_reset, s_ready);
        end
        s_valid = 1'b1; s_data = 8'h60; s_last = 1'b1;
      end
      if (t == 10) s_valid = 1'b0;
    end
    #1;
    checks++;
    if (fd_n - base != 1 || last_fm != 0) begin
      errors++; $display("FAIL gap_frames count=%0d fm=%0d required 1 0", fd_n - base, last_fm);
    end
  endtask

  task automatic test_saturate;
    int base;
    int exp_mc[4] = '{1, 2, 3, 3};
    cnt_clr = 1'b1; @(negedge clk); cnt_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      base = fd_n;
      send_word(8'hB0, 1'b1, 0);
      wait_fd(base + 1);
      checks++;
      if (int'(match_count2) != exp_mc[i]) begin
        errors++; $display("FAIL sat_count frame %0d got %0d required %0d", i, match_count2, exp_mc[i]);
      end
    end
  endtask

  task automatic test_clear;
    s_valid = 1'b1; s_data = 8'hB0; s_last = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      if (t == 1) s_valid = 1'b0;
      if (t == 5) cnt_clr = 1'b1;
      if (t == 6) begin
        cnt_clr = 1'b0;
        checks++;
        if (match_count !== 16'd0 || match_count2 !== 2'd0) begin
          errors++; $display("FAIL clear_wins mc=%0d mc2=%0d required 0 0", match_count, match_count2);
        end
      end
      if (t == 10) begin
        checks++;
        if (frame_done2 !== 1'b1 || frame_matches2 !== 2'd1 || match_count2 !== 2'd0) begin
          errors++;
          $display("FAIL clear_frame fd=%0b fm=%0d mc=%0d required 1 1 0", frame_done2, frame_matches2, match_count2);
        end
      end
    end
  endtask

  task automatic test_reset_midword;
    int base;
    s_valid = 1'b1; s_data = 8'hB6; s_last = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      if (t == 1) s_valid = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, det_reset, det_bit, frame_done} !== 4'b1100 || frame_matches !== 16'd0) begin
      errors++;
      $display("FAIL midword_reset rdy=%0b drst=%0b bit=%0b fd=%0b fm=%0d required 1 1 0 0 0",
               s_ready, det_reset, det_bit, frame_done, frame_matches);
    end
    base = fd_n;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    checks++;
    if (fd_n != base) begin errors++; $display("FAIL midword_no_done got %0d frames required 0", fd_n - base); end
    send_word(8'hB6, 1'b1, 0);
    wait_fd(base + 1);
    checks++;
    if (last_fm != 1 || match_count !== 16'd1) begin
      errors++; $display("FAIL midword_next fm=%0d mc=%0d required 1 1", last_fm, match_count);
    end
  endtask

  task automatic test_random;
    int exp_q[$];
    int total = 0;
    int base, nw, gap, rs, cnt;
    logic [7:0] d;
    cnt_clr = 1'b1; @(negedge clk); cnt_clr = 1'b0;
    base = fd_n;
    fm_q.delete();
    for (int f = 0; f < 12; f++) begin
      nw = $urandom_range(1, 3);
      rs = 0; cnt = 0;
      for (int w = 0; w < nw; w++) begin
        d = 8'($urandom);
        gap = (w == 0) ? $urandom_range(0, 2) : (($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0);
        if (w > 0 && gap > 0) rs = 0;
        for (int b = 7; b >= 0; b--) begin
          rs = det_next(rs, d[b]);
          if (rs == 4) cnt++;
        end
        send_word(d, (w == nw - 1), gap);
      end
      exp_q.push_back(cnt);
      total += cnt;
    end
    wait_fd(base + 12);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (i >= fm_q.size() || fm_q[i] != exp_q[i]) begin
        errors++;
        $display("FAIL random_frame %0d got %0d required %0d", i, (i < fm_q.size()) ? fm_q[i] : -1, exp_q[i]);
      end
    end
    checks++;
    if (int'(match_count) != total) begin
      errors++; $display("FAIL random_total got %0d required %0d", match_count, total);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_gap;
    test_saturate;
    test_clear;
    test_reset_midword;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
